esfa_cell_bank: RTL

ESFA_CELL_BANK -- requirements
Module: esfa_cell_bank

---
 rtl/esfa_pkg.sv | 44 ++++
 rtl/esfa_cell.sv | 149 ++++++++++++++
 rtl/esfa_cell_bank.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/esfa_pkg.sv
// Shared types for the ESFA cell bank: opcodes, controller states, per-cell flags
// and opcode classification helpers.
package esfa_pkg;

  localparam int OP_W   = 4;
  localparam int FLAG_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_UPDATE       = 4'd0,
    OP_LOOKUP       = 4'd1,
    OP_ENCODE       = 4'd2,
    OP_CONGRUE_UP   = 4'd3,
    OP_CONGRUE_DOWN = 4'd4,
    OP_FIND_FREE    = 4'd5,
    OP_ENRANK       = 4'd6
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic arr_def;
    logic elt_def;
  } cell_flags_t;

  // Opcodes that address a single cell through cmd_handle.
  function automatic logic op_needs_handle(op_e op);
    case (op)
      OP_UPDATE, OP_ENCODE, OP_CONGRUE_UP, OP_CONGRUE_DOWN, OP_ENRANK: return 1'b1;
      default:                                                        return 1'b0;
    endcase
  endfunction

  function automatic logic op_writes(op_e op);
    case (op)
      OP_UPDATE, OP_CONGRUE_UP, OP_CONGRUE_DOWN: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/esfa_cell.sv
// One ESFA memory cell: holds its state, computes its next state for the command
// under execution and reports whether it matches that command.
module esfa_cell
  import esfa_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              commit,
  input  logic              sel,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] cmd_handle,
  input  logic [DATA_W-1:0] cmd_index,
  input  logic [DATA_W-1:0] cmd_value,
  input  logic [DATA_W-1:0] cmd_code,
  input  logic [DATA_W-1:0] cmd_rank,
  input  logic              cmd_code_valid,
  output logic              match,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] ctx,
  output logic              free_next
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  cell_flags_t       flags, flags_nxt;
  logic [DATA_W-1:0] code, rank, low, high, index, value;
  logic [DATA_W-1:0] code_nxt, rank_nxt, low_nxt, high_nxt, index_nxt, value_nxt;
  logic              kill;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    flags_nxt = flags;
    code_nxt  = code;
    rank_nxt  = rank;
    low_nxt   = low;
    high_nxt  = high;
    index_nxt = index;
    value_nxt = value;
    kill      = 1'b0;
    if (commit) begin
      case (op_e'(op))
        OP_UPDATE: begin
          if (sel) begin
            flags_nxt = '{arr_def: 1'b1, elt_def: 1'b1};
            code_nxt  = cmd_handle;
            low_nxt   = cmd_handle;
            high_nxt  = cmd_handle;
            index_nxt = cmd_index;
            value_nxt = cmd_value;
            rank_nxt  = ONE;
          end
        end
        OP_CONGRUE_UP: begin
          if (sel) begin
            flags_nxt = '{arr_def: 1'b1, elt_def: 1'b1};
            code_nxt  = cmd_code + ONE;
            low_nxt   = cmd_code + ONE;
            high_nxt  = cmd_code + ONE;
            rank_nxt  = cmd_rank + ONE;
          end else begin
            if (flags.arr_def && code > cmd_code) code_nxt = code + ONE;
            if (flags.elt_def) begin
              if (low > cmd_code)   low_nxt  = low + ONE;
              if (high >= cmd_code) high_nxt = high + ONE;
            end
          end
        end
        OP_CONGRUE_DOWN: begin
          if (sel) begin
            flags_nxt.arr_def = 1'b0;
            rank_nxt          = '0;
          end
          if (flags.elt_def) begin
            if (cmd_code < low) begin
              low_nxt  = low - ONE;
              high_nxt = high - ONE;
              kill     = (low > high);
            end else if (cmd_code <= high) begin
              // Shrinking a single-point range empties it; test before high wraps.
              high_nxt = high - ONE;
              kill     = (high == low);
            end
          end
          if (kill) flags_nxt = '{arr_def: 1'b0, elt_def: 1'b0};
          if (flags_nxt.arr_def && code > cmd_code) code_nxt = code - ONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    match  = 1'b0;
    result = '0;
    ctx    = '0;
    case (op_e'(op))
      OP_UPDATE, OP_CONGRUE_UP, OP_CONGRUE_DOWN: begin
        match  = sel;
        result = cmd_handle;
        ctx    = cmd_handle;
      end
      OP_LOOKUP: begin
        match  = flags.elt_def && cmd_code_valid && (index == cmd_index) &&
                 (low <= cmd_code) && (cmd_code <= high);
        result = value;
        ctx    = rank;
      end
      OP_ENCODE: begin
        match  = sel && flags.arr_def;
        result = code;
        ctx    = code;
      end
      OP_ENRANK: begin
        match  = sel && flags.arr_def;
        result = rank;
        ctx    = rank;
      end
      OP_FIND_FREE: match = !flags.elt_def;
      default: ;
    endcase
  end

  assign free_next = !flags_nxt.elt_def;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      // NOTE: the cell fields are a small register file that must come up empty, so they are reset explicitly rather than left to a RAM.
      flags <= '0;
      code  <= '0;
      rank  <= '0;
      low   <= '0;
      high  <= '0;
      index <= '0;
      value <= '0;
    end else begin
      flags <= flags_nxt;
      code  <= code_nxt;
      rank  <= rank_nxt;
      low   <= low_nxt;
      high  <= high_nxt;
      index <= index_nxt;
      value <= value_nxt;
    end
  end

endmodule

// File: rtl/esfa_cell_bank.sv
// ESFA cell bank: accepts one command at a time, executes it across all cells in a
// single cycle and holds the prioritised response until it is taken.
module esfa_cell_bank
  import esfa_pkg::*;
#(
  parameter  int NUM_CELLS = 8,
  parameter  int DATA_W    = 8,
  localparam int H_W       = $clog2(NUM_CELLS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_handle,
  input  logic [DATA_W-1:0] cmd_index,
  input  logic [DATA_W-1:0] cmd_value,
  input  logic [DATA_W-1:0] cmd_code,
  input  logic [DATA_W-1:0] cmd_rank,
  input  logic              cmd_code_valid,
  input  logic              cmd_rank_valid,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_hit,
  output logic              rsp_error,
  output logic [H_W-1:0]    rsp_handle,
  output logic [DATA_W-1:0] rsp_result,
  output logic [DATA_W-1:0] rsp_context,
  output logic [H_W:0]      free_count
);

  localparam logic [DATA_W:0] NUM_CELLS_W = (DATA_W+1)'(NUM_CELLS);

  state_e            state, state_nxt;
  logic              accept;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] handle_q, index_q, value_q, code_q, rank_q;
  logic              code_valid_q, rank_valid_q;
  logic              handle_ok, cmd_error, commit;

  logic [NUM_CELLS-1:0] sel, match, free_next;
  logic [DATA_W-1:0]    cell_result [NUM_CELLS];
  logic [DATA_W-1:0]    cell_ctx    [NUM_CELLS];

  logic [H_W-1:0]    hit_idx, handle_d;
  logic              hit_d;
  logic [DATA_W-1:0] result_d, ctx_d;
  logic [H_W:0]      free_cnt_d;

  assign accept = cmd_valid && cmd_ready;

  // The command is captured at acceptance so EXEC sees stable operands.
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q         <= '0;
      handle_q     <= '0;
      index_q      <= '0;
      value_q      <= '0;
      code_q       <= '0;
      rank_q       <= '0;
      code_valid_q <= 1'b0;
      rank_valid_q <= 1'b0;
    end else if (accept) begin
      op_q         <= cmd_op;
      handle_q     <= cmd_handle;
      index_q      <= cmd_index;
      value_q      <= cmd_value;
      code_q       <= cmd_code;
      rank_q       <= cmd_rank;
      code_valid_q <= cmd_code_valid;
      rank_valid_q <= cmd_rank_valid;
    end
  end

  assign handle_ok = ({1'b0, handle_q} < NUM_CELLS_W);

  always_comb begin
    cmd_error = 1'b0;
    case (op_e'(op_q))
      OP_CONGRUE_UP:   cmd_error = !code_valid_q || !rank_valid_q ||
                                   (code_q == '1) || (rank_q == '1);
      OP_CONGRUE_DOWN: cmd_error = !code_valid_q;
      OP_UPDATE, OP_LOOKUP, OP_ENCODE, OP_FIND_FREE, OP_ENRANK: ;
      default:         cmd_error = 1'b1;
    endcase
    if (op_needs_handle(op_e'(op_q)) && !handle_ok) cmd_error = 1'b1;
  end

  assign commit = (state == ST_EXEC) && !cmd_error && op_writes(op_e'(op_q));

  for (genvar i = 0; i < NUM_CELLS; i++) begin : g_cell
    assign sel[i] = handle_ok && (handle_q[H_W-1:0] == H_W'(i));

    esfa_cell #(.DATA_W(DATA_W)) u_cell (
      .clk            (clk),
      .reset          (reset),
      .commit         (commit),
      .sel            (sel[i]),
      .op             (op_q),
      .cmd_handle     (handle_q),
      .cmd_index      (index_q),
      .cmd_value      (value_q),
      .cmd_code       (code_q),
      .cmd_rank       (rank_q),
      .cmd_code_valid (code_valid_q),
      .match          (match[i]),
      .result         (cell_result[i]),
      .ctx            (cell_ctx[i]),
      .free_next      (free_next[i])
    );
  end

  // Scanning downward leaves the lowest matching index in hit_idx.
  always_comb begin
    hit_idx = '0;
    for (int i = NUM_CELLS - 1; i >= 0; i--) begin
      if (match[i]) hit_idx = H_W'(i);
    end
  end

  always_comb begin
    hit_d    = (|match) && !cmd_error;
    handle_d = '0;
    result_d = '0;
    ctx_d    = '0;
    if (hit_d) begin
      handle_d = hit_idx;
      if (op_e'(op_q) == OP_FIND_FREE) begin
        result_d = DATA_W'(hit_idx);
        ctx_d    = DATA_W'(hit_idx);
      end else begin
        result_d = cell_result[hit_idx];
        ctx_d    = cell_ctx[hit_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_hit     <= 1'b0;
      rsp_error   <= 1'b0;
      rsp_handle  <= '0;
      rsp_result  <= '0;
      rsp_context <= '0;
    end else if (state == ST_EXEC) begin
      rsp_hit     <= hit_d;
      rsp_error   <= cmd_error;
      rsp_handle  <= handle_d;
      rsp_result  <= result_d;
      rsp_context <= ctx_d;
    end
  end

  // Counting the next-state flags makes free_count follow a commit on the same edge.
  always_comb begin
    free_cnt_d = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      free_cnt_d = free_cnt_d + (H_W+1)'(free_next[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) free_count <= (H_W+1)'(NUM_CELLS);
    else        free_count <= free_cnt_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cmd_valid) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
  end

endmodule
